// File: rtl/cp0_unit.sv
// Coprocessor-0: Status/Cause/EPC, ext-interrupt synchroniser and exception arbitration.
// Latency: trap/rdata/epc_out are combinational; state updates on the next edge. Stall freezes architectural state.
module cp0_unit #(
    parameter logic [31:0] VECTOR    = 32'h0000_0004,
    parameter logic [31:0] EPC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        cp0_write,
    input  logic        cp0_read_epc,
    input  logic        cp0_write_epc,
    input  logic [1:0]  int_code,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] pc_next,
    input  logic        ext_int,
    output logic [31:0] rdata,
    output logic [31:0] epc_out,
    output logic        trap,
    output logic [31:0] vector_out,
    output logic [1:0]  cause_code
);

    logic        r_ie, r_pie, r_eim;
    logic [1:0]  r_code;
    logic [31:0] r_epc;
    logic        r_s1, r_s2, r_s3;
    logic        r_pending;

    logic        w_edge;
    logic        w_ext_req;
    logic        w_trap;
    logic        w_take_ext;
    logic [1:0]  w_code;

    assign w_edge     = r_s2 & ~r_s3;
    assign w_ext_req  = (int_code == 2'b01) | (r_pending & r_ie & r_eim);
    // Illegal/overflow are non-maskable and outrank any external request.
    assign w_trap     = ~stall & (int_code[1] | w_ext_req);
    assign w_take_ext = w_trap & ~int_code[1];
    assign w_code     = int_code[1] ? int_code : 2'b01;

    assign trap       = w_trap;
    assign vector_out = VECTOR;
    assign epc_out    = r_epc;
    assign cause_code = r_code;

    always_comb begin
        rdata = 32'd0;
        case (addr)
            5'd12:   rdata = {29'd0, r_eim, r_pie, r_ie};
            5'd13:   rdata = {23'd0, r_pending, 4'd0, r_code, 2'd0};
            5'd14:   rdata = r_epc;
            default: rdata = 32'd0;
        endcase
    end

    // Synchroniser and pending latch run regardless of stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_s3      <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_s1 <= ext_int;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            if (w_take_ext)
                r_pending <= 1'b0;
            else if (w_edge)
                r_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ie   <= 1'b0;
            r_pie  <= 1'b0;
            r_eim  <= 1'b0;
            r_code <= 2'b00;
            r_epc  <= EPC_RESET;
        end else if (!stall) begin
            if (w_trap) begin
                r_epc  <= int_code[1] ? pc : pc_next;
                r_code <= w_code;
                r_pie  <= r_ie;
                r_ie   <= 1'b0;
            end else begin
                if (cp0_write && addr == 5'd12) begin
                    r_ie  <= wdata[0];
                    r_pie <= wdata[1];
                    r_eim <= wdata[2];
                end
                if (cp0_read_epc)
                    r_ie <= r_pie;
                // syscall EPC capture outranks an mtc0 to EPC in the same cycle.
                if (cp0_write_epc)
                    r_epc <= pc_plus4;
                else if (cp0_write && addr == 5'd14)
                    r_epc <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: reset, illegal, ext interrupt, arbitration, syscall/eret, stall.
`timescale 1ns/1ps
module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        cp0_write;
    logic        cp0_read_epc;
    logic        cp0_write_epc;
    logic [1:0]  int_code;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic        ext_int;
    logic [31:0] rdata;
    logic [31:0] epc_out;
    logic        trap;
    logic [31:0] vector_out;
    logic [1:0]  cause_code;

    int n_tests = 0;
    int n_fail  = 0;

    cp0_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .cp0_write(cp0_write), .cp0_read_epc(cp0_read_epc), .cp0_write_epc(cp0_write_epc),
        .int_code(int_code), .addr(addr), .wdata(wdata),
        .pc(pc), .pc_plus4(pc_plus4), .pc_next(pc_next), .ext_int(ext_int),
        .rdata(rdata), .epc_out(epc_out), .trap(trap), .vector_out(vector_out),
        .cause_code(cause_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_write = 1'b1; addr = a; wdata = d;
        tick();
        cp0_write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a);
        addr = a;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; cp0_write = 1'b0; cp0_read_epc = 1'b0;
        cp0_write_epc = 1'b0; int_code = 2'b00; addr = 5'd12; wdata = 32'd0;
        pc = 32'd0; pc_plus4 = 32'd4; pc_next = 32'd4; ext_int = 1'b0;
        tick();
        rd(5'd12); chk("rst_status", rdata, 32'h0);
        rd(5'd13); chk("rst_cause", rdata, 32'h0);
        chk("rst_epc", epc_out, 32'h0);
        chk("rst_trap", {31'd0, trap}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Async reset mid-cycle
        mtc0(5'd14, 32'h0000_0040);
        mtc0(5'd12, 32'h0000_0007);
        rd(5'd12); chk("pre_rst_status", rdata, 32'h7);
        chk("pre_rst_epc", epc_out, 32'h40);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_status", rdata, 32'h0);
        chk("arst_epc", epc_out, 32'h0);
        chk("arst_code", {30'd0, cause_code}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Illegal instruction
        mtc0(5'd12, 32'h5);
        pc = 32'h100; int_code = 2'b10;
        #1;
        chk("ill_trap", {31'd0, trap}, 32'h1);
        chk("ill_vector", vector_out, 32'h4);
        tick();
        int_code = 2'b00;
        #1;
        chk("ill_epc", epc_out, 32'h100);
        rd(5'd13); chk("ill_cause", rdata, 32'h8);
        rd(5'd12); chk("ill_status", rdata, 32'h6);

        // External interrupt: raised before edge 0, trap in cycle after edge 2
        mtc0(5'd12, 32'h5);
        pc_next = 32'h208;
        ext_int = 1'b1;
        tick();
        chk("ext_e0_trap", {31'd0, trap}, 32'h0);
        tick();
        chk("ext_e1_trap", {31'd0, trap}, 32'h0);
        rd(5'd13); chk("ext_e1_cause", rdata, 32'h8);
        tick();
        chk("ext_e2_trap", {31'd0, trap}, 32'h1);
        chk("ext_e2_cause", rdata, 32'h108);
        tick();
        chk("ext_epc", epc_out, 32'h208);
        chk("ext_cause", rdata, 32'h4);
        rd(5'd12); chk("ext_status", rdata, 32'h6);
        chk("ext_trap_off", {31'd0, trap}, 32'h0);

        // Simultaneous illegal and pending ext
        ext_int = 1'b0;
        tick(); tick(); tick();
        ext_int = 1'b1;
        tick(); tick(); tick();
        rd(5'd13); chk("sim_pend", rdata, 32'h104);
        chk("sim_masked", {31'd0, trap}, 32'h0);
        mtc0(5'd12, 32'h5);
        int_code = 2'b10; pc = 32'h300;
        #1;
        chk("sim_trap", {31'd0, trap}, 32'h1);
        tick();
        int_code = 2'b00;
        rd(5'd13);
        chk("sim_code", {30'd0, cause_code}, 32'h2);
        chk("sim_pend_kept", rdata, 32'h108);
        chk("sim_epc", epc_out, 32'h300);
        cp0_read_epc = 1'b1;
        #1;
        chk("sim_eret_epc", epc_out, 32'h300);
        chk("sim_eret_notrap", {31'd0, trap}, 32'h0);
        tick();
        cp0_read_epc = 1'b0;
        #1;
        chk("sim_ext_trap", {31'd0, trap}, 32'h1);
        tick();
        chk("sim_ext_code", {30'd0, cause_code}, 32'h1);
        chk("sim_ext_cause", rdata, 32'h4);
        chk("sim_ext_epc", epc_out, 32'h208);

        // syscall then eret
        pc_plus4 = 32'h44; cp0_write_epc = 1'b1;
        #1;
        chk("sys_notrap", {31'd0, trap}, 32'h0);
        tick();
        cp0_write_epc = 1'b0;
        chk("sys_epc", epc_out, 32'h44);
        chk("sys_code", {30'd0, cause_code}, 32'h1);
        cp0_read_epc = 1'b1;
        #1;
        chk("eret_epc", epc_out, 32'h44);
        tick();
        cp0_read_epc = 1'b0;
        rd(5'd12); chk("eret_status", rdata, 32'h7);

        // syscall wins over mtc0 to EPC
        cp0_write = 1'b1; addr = 5'd14; wdata = 32'h1234; cp0_write_epc = 1'b1; pc_plus4 = 32'h80;
        tick();
        cp0_write = 1'b0; cp0_write_epc = 1'b0;
        chk("epc_prio", epc_out, 32'h80);
        rd(5'd5); chk("unmapped", rdata, 32'h0);

        // Stall blocks updates but not the ext path
        ext_int = 1'b0;
        tick(); tick(); tick();
        stall = 1'b1; int_code = 2'b10; cp0_write = 1'b1; addr = 5'd14; wdata = 32'hDEAD;
        ext_int = 1'b1;
        #1;
        chk("stall_trap", {31'd0, trap}, 32'h0);
        tick(); tick(); tick();
        chk("stall_epc", epc_out, 32'h80);
        rd(5'd13); chk("stall_pend", rdata, 32'h104);
        chk("stall_trap2", {31'd0, trap}, 32'h0);
        stall = 1'b0; int_code = 2'b00; cp0_write = 1'b0;
        #1;
        chk("unstall_trap", {31'd0, trap}, 32'h1);
        tick();
        chk("unstall_epc", epc_out, 32'h208);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
